debounce3: RTL and testbench

Three-channel synchronizer and debouncer for mechanical slide switches on the STEPFPGA board. It takes three raw, asynchronous, bouncing switch levels and produces three clean, clock-synchronous levels for the downstream 3-input XOR gate's A, B and C inputs. It also emits a one-cycle change strobe so later stages can react to a new input combination without edge-detecting it themselves.

---
 rtl/debounce3.sv | 72 +++++++
 tb/tb_debounce3.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/debounce3.sv
// Three-channel 2-flop synchronizer and counter-based debouncer for slide switches.
// Outputs are registered; chg pulses for one cycle whenever any debounced level updates.
module debounce3 #(
  parameter int unsigned CNT_MAX = 240000,
  parameter int unsigned CNT_W   = $clog2(CNT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
  input  logic sw_c,
  output logic a_db,
  output logic b_db,
  output logic c_db,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [2:0]            sw_raw;
  logic [2:0]            q1_q, q1_d;
  logic [2:0]            q2_q, q2_d;
  logic [2:0]            db_q, db_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            upd;
  logic                  chg_q, chg_d;

  assign sw_raw = {sw_a, sw_b, sw_c};

  always_comb begin
    q1_d  = sw_raw;
    q2_d  = q1_q;
    db_d  = db_q;
    cnt_d = cnt_q;
    upd   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      // A match with the current output discards progress, even on the final count.
      if (q2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = q2_q[i];
        cnt_d[i] = '0;
        upd[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    chg_d = |upd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q  <= '0;
      q2_q  <= '0;
      db_q  <= '0;
      cnt_q <= '0;
      chg_q <= 1'b0;
    end else begin
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      db_q  <= db_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
    end
  end

  assign a_db = db_q[2];
  assign b_db = db_q[1];
  assign c_db = db_q[0];
  assign chg  = chg_q;

endmodule

// File: tb/tb_debounce3.sv
// Self-checking bench for debounce3: directed scenarios then random switch activity,
// compared every cycle against a history-window reference model.
module tb_debounce3;

  localparam int unsigned CNT_MAX = 4;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst;
  logic sw_a, sw_b, sw_c;
  logic a_db, b_db, c_db, chg;

  always #5 clk = ~clk;

  debounce3 #(
    .CNT_MAX(CNT_MAX),
    .CNT_W  ($clog2(CNT_MAX))
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw_a(sw_a),
    .sw_b(sw_b),
    .sw_c(sw_c),
    .a_db(a_db),
    .b_db(b_db),
    .c_db(c_db),
    .chg (chg)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: hist[n] is the switch level captured by the first sync flop at edge n,
  // so the synchronized level seen at edge m is hist[m-2]. A channel updates at edge n when
  // the synchronized level differed from the output at every one of the last CNT_MAX edges,
  // none of which precede that channel's last update or reset.
  logic [2:0] hist [HMAX];
  int         n = 1;
  int         last [3];
  logic [2:0] m_db  = '0;
  logic       m_chg = 1'b0;

  task automatic model_edge(input logic r, input logic [2:0] sw);
    logic [2:0] upd;
    bit ok;
    n++;
    if (r) begin
      hist[n]   = '0;
      hist[n-1] = '0;
      m_db      = '0;
      m_chg     = 1'b0;
      for (int ch = 0; ch < 3; ch++) last[ch] = n;
    end else begin
      hist[n] = sw;
      upd     = '0;
      for (int ch = 0; ch < 3; ch++) begin
        ok = (n - int'(CNT_MAX)) >= last[ch];
        if (ok)
          for (int k = 0; k < int'(CNT_MAX); k++)
            if (hist[n-k-2][ch] == m_db[ch]) ok = 0;
        if (ok) begin
          upd[ch]  = 1'b1;
          last[ch] = n;
        end
      end
      m_db  = m_db ^ upd;
      m_chg = |upd;
    end
  endtask

  task automatic step(input logic r, input logic [2:0] sw);
    rst = r;
    {sw_a, sw_b, sw_c} = sw;
    @(posedge clk);
    model_edge(r, sw);
    #1;
    checks++;
    assert ({a_db, b_db, c_db, chg} === {m_db, m_chg})
    else begin
      errors++;
      $error("FAIL step edge=%0d: observed a,b,c,chg=%b required %b",
             n, {a_db, b_db, c_db, chg}, {m_db, m_chg});
    end
  endtask

  task automatic check_const(input string tag, input logic [3:0] exp);
    checks++;
    assert ({a_db, b_db, c_db, chg} === exp)
    else begin
      errors++;
      $error("FAIL %s: observed a,b,c,chg=%b required %b", tag, {a_db, b_db, c_db, chg}, exp);
    end
  endtask

  initial begin
    logic [2:0] sw_r;
    logic       r_r;
    rst = 1'b1;
    {sw_a, sw_b, sw_c} = 3'b000;

    // Reset with all switches high, then release: fresh change after full latency.
    repeat (3) step(1'b1, 3'b111);
    check_const("reset_hold", 4'b0000);
    repeat (5) step(1'b0, 3'b111);
    check_const("reset_release_pre", 4'b0000);
    step(1'b0, 3'b111);
    check_const("reset_release_edge6", 4'b1111);
    step(1'b0, 3'b111);
    check_const("reset_release_chg_once", 4'b1110);

    // Clean edge on b.
    step(1'b1, 3'b000);
    repeat (6) step(1'b0, 3'b010);
    check_const("clean_b_edge6", 4'b0101);
    step(1'b0, 3'b010);
    check_const("clean_b_after", 4'b0100);

    // Bounce rejection on c.
    step(1'b1, 3'b000);
    repeat (2) begin
      repeat (3) step(1'b0, 3'b001);
      repeat (3) step(1'b0, 3'b000);
    end
    check_const("bounce_held", 4'b0000);
    repeat (5) step(1'b0, 3'b001);
    check_const("bounce_pre", 4'b0000);
    step(1'b0, 3'b001);
    check_const("bounce_c_edge6", 4'b0011);

    // Glitch on a shorter than CNT_MAX.
    step(1'b1, 3'b000);
    repeat (3) step(1'b0, 3'b100);
    repeat (8) step(1'b0, 3'b000);
    check_const("glitch_a", 4'b0000);

    // Staggered a then b.
    step(1'b1, 3'b000);
    step(1'b0, 3'b100);
    repeat (5) step(1'b0, 3'b110);
    check_const("stagger_a_edge6", 4'b1001);
    step(1'b0, 3'b110);
    check_const("stagger_b_edge7", 4'b1101);

    // Reset mid-count restarts the whole latency.
    step(1'b1, 3'b000);
    repeat (3) step(1'b0, 3'b100);
    step(1'b1, 3'b100);
    repeat (5) step(1'b0, 3'b100);
    check_const("midreset_pre", 4'b0000);
    step(1'b0, 3'b100);
    check_const("midreset_edge6", 4'b1001);

    // Random activity: mostly held levels with occasional toggles and rare resets.
    sw_r = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 5) == 0) sw_r[ch] = ~sw_r[ch];
      r_r = ($urandom_range(0, 99) == 0);
      step(r_r, sw_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
